// File: rtl/ana_pad_mux_seq.sv
// ana_pad_mux_seq: break-before-make sequencer for the analog pad ring switches.
// Every change of connection opens all switches for DEAD_CYC cycles before closing the new one.
module ana_pad_mux_seq #(
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = 2,
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              req_disc,
    output logic              req_ready,
    output logic [NUM_CH-1:0] sw_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SEL_W-1:0]  cur_sel,
    output logic              connected
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  timer, timer_nxt;
    logic [SEL_W-1:0]  target, target_nxt;
    logic              has_target, has_target_nxt;
    logic [NUM_CH-1:0] sw_en_nxt;
    logic              done_nxt, err_nxt, connected_nxt;
    logic [SEL_W-1:0]  cur_sel_nxt;
    logic              accept, sel_ok;

    assign accept = req_valid && req_ready;
    assign sel_ok = int'(req_sel) < NUM_CH;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        target_nxt     = target;
        has_target_nxt = has_target;
        sw_en_nxt      = sw_en;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        connected_nxt  = connected;
        cur_sel_nxt    = cur_sel;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_disc) begin
                        sw_en_nxt      = '0;
                        connected_nxt  = 1'b0;
                        timer_nxt      = DEAD_LOAD;
                        has_target_nxt = 1'b0;
                        state_nxt      = BREAK;
                    end else if (!sel_ok) begin
                        err_nxt = 1'b1;
                    end else if (connected && (req_sel == cur_sel)) begin
                        done_nxt = 1'b1;
                    end else begin
                        sw_en_nxt      = '0;
                        connected_nxt  = 1'b0;
                        timer_nxt      = DEAD_LOAD;
                        target_nxt     = req_sel;
                        has_target_nxt = 1'b1;
                        state_nxt      = BREAK;
                    end
                end
            end

            // All switches stay open for the full dead time before any make.
            BREAK: begin
                sw_en_nxt = '0;
                if (timer == '0) begin
                    if (has_target) begin
                        sw_en_nxt = NUM_CH'(1) << target;
                        timer_nxt = SETTLE_LOAD;
                        state_nxt = MAKE;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - CNT_ONE;
                end
            end

            MAKE: begin
                if (timer == '0) begin
                    connected_nxt = 1'b1;
                    cur_sel_nxt   = target;
                    done_nxt      = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    timer_nxt = timer - CNT_ONE;
                end
            end

            default: begin
                sw_en_nxt     = '0;
                connected_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    // req_ready is registered so it only rises on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            target     <= '0;
            has_target <= 1'b0;
            sw_en      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            connected  <= 1'b0;
            cur_sel    <= '0;
            req_ready  <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            target     <= target_nxt;
            has_target <= has_target_nxt;
            sw_en      <= sw_en_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            connected  <= connected_nxt;
            cur_sel    <= cur_sel_nxt;
            req_ready  <= (state_nxt == IDLE);
        end
    end

endmodule
